// File: rtl/eth_rxframe_ctrl_pkg.sv
// Shared constants and types for the Ethernet receive frame controller.
// Covers the IFG target, delayed-CRC depth and counter widths.
package eth_rxframe_ctrl_pkg;

  localparam int unsigned IfgTarget   = 24;
  localparam int unsigned DlyCrcDepth = 4;
  localparam int unsigned ByteCntW    = 16;
  localparam int unsigned IfgCntW     = 5;
  localparam int unsigned DlyCrcCntW  = 3;

  typedef logic [ByteCntW-1:0] byte_cnt_t;
  typedef logic [IfgCntW-1:0]  ifg_cnt_t;

  // Saturating increment: the byte counter must never wrap back to zero.
  function automatic byte_cnt_t byte_cnt_sat_inc(input byte_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + byte_cnt_t'(1);
  endfunction

endpackage

// File: rtl/eth_rxframe_ifgcnt.sv
// Inter-frame gap counter: counts idle/preamble/SFD cycles up to the IFG target
// and reports when the gap has been met (or is overridden).
module eth_rxframe_ifgcnt
  import eth_rxframe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic state_drop,
  input  logic ifg_run,
  input  logic r_ifg,
  output logic ifg_eq24
);

  localparam ifg_cnt_t Target = ifg_cnt_t'(IfgTarget);

  ifg_cnt_t ifg_cnt_q, ifg_cnt_d;

  // Clear wins over increment, so a frame start in StateSFD restarts the gap.
  always_comb begin
    ifg_cnt_d = ifg_cnt_q;
    if (frame_start | state_drop) begin
      ifg_cnt_d = '0;
    end else if (ifg_run && (ifg_cnt_q < Target)) begin
      ifg_cnt_d = ifg_cnt_q + ifg_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifg_cnt_q <= '0;
    end else begin
      ifg_cnt_q <= ifg_cnt_d;
    end
  end

  assign ifg_eq24 = (ifg_cnt_q == Target) | r_ifg;

endmodule

// File: rtl/eth_rxframe_ctrl.sv
// Receive frame byte counter, status flags, IFG tracking and end-of-frame pulse.
// Delayed-CRC byte skipping is built only when ETH_RX_DLYCRC_EN is defined.
module eth_rxframe_ctrl
  import eth_rxframe_ctrl_pkg::*;
#(
  parameter int Tp = 1
) (
  input  logic        MRxClk,
  input  logic        Reset,
  input  logic        MRxDV,
  input  logic        MRxDEqD,
  input  logic        StateIdle,
  input  logic        StatePreamble,
  input  logic        StateSFD,
  input  logic        StateDrop,
  input  logic [1:0]  StateData,
  input  logic        HugEn,
  input  logic        r_IFG,
  input  logic [15:0] MaxFL,
  input  logic        DlyCrcEn,
  output logic [15:0] ByteCnt,
  output logic        ByteCntEq0,
  output logic        ByteCntGreat2,
  output logic        ByteCntMaxFrame,
  output logic        IFGCounterEq24,
  output logic        FrameEnd
);

  // Tp is kept for interface compatibility; register delays are not modelled.
  if (Tp < 0) begin : g_tp_invalid
    $error("Tp must be non-negative");
  end

  logic      frame_start;
  logic      cnt_clr;
  logic      byte_valid;
  logic      byte_cnt_inc;
  byte_cnt_t byte_cnt_q, byte_cnt_d;
  logic      frame_end_q, frame_end_d;

  assign frame_start = MRxDV & StateSFD & MRxDEqD;
  assign cnt_clr     = frame_start | StateIdle | StateDrop;
  assign byte_valid  = MRxDV & StateData[1];

`ifdef ETH_RX_DLYCRC_EN
  localparam logic [DlyCrcCntW-1:0] DlyDepth = DlyCrcCntW'(DlyCrcDepth);

  logic [DlyCrcCntW-1:0] dly_cnt_q, dly_cnt_d;
  logic                  dly_active;

  // The first DlyDepth bytes of a delayed-CRC frame are absorbed here.
  assign dly_active   = DlyCrcEn & (dly_cnt_q != DlyDepth);
  assign byte_cnt_inc = byte_valid & ~dly_active;

  always_comb begin
    dly_cnt_d = dly_cnt_q;
    if (cnt_clr) begin
      dly_cnt_d = '0;
    end else if (byte_valid & dly_active) begin
      dly_cnt_d = dly_cnt_q + DlyCrcCntW'(1);
    end
  end

  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      dly_cnt_q <= '0;
    end else begin
      dly_cnt_q <= dly_cnt_d;
    end
  end
`else
  logic unused_dlycrc;
  assign unused_dlycrc = DlyCrcEn;
  assign byte_cnt_inc  = byte_valid;
`endif

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (cnt_clr) begin
      byte_cnt_d = '0;
    end else if (byte_cnt_inc) begin
      byte_cnt_d = byte_cnt_sat_inc(byte_cnt_q);
    end
  end

  always_comb begin
    frame_end_d = (|StateData) & ~MRxDV;
  end

  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      byte_cnt_q  <= '0;
      frame_end_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      frame_end_q <= frame_end_d;
    end
  end

  eth_rxframe_ifgcnt u_ifgcnt (
    .clk         (MRxClk),
    .rst         (Reset),
    .frame_start (frame_start),
    .state_drop  (StateDrop),
    .ifg_run     (StateIdle | StatePreamble | StateSFD),
    .r_ifg       (r_IFG),
    .ifg_eq24    (IFGCounterEq24)
  );

  assign ByteCnt         = byte_cnt_q;
  assign ByteCntEq0      = (byte_cnt_q == '0);
  assign ByteCntGreat2   = (byte_cnt_q > byte_cnt_t'(2));
  assign ByteCntMaxFrame = (byte_cnt_q == MaxFL) & ~HugEn;
  assign FrameEnd        = frame_end_q;

endmodule

// File: tb/tb_eth_rxframe_ctrl.sv
// Self-checking bench for eth_rxframe_ctrl with a per-byte expected-value scoreboard.
module tb_eth_rxframe_ctrl;

  logic        MRxClk = 1'b0;
  logic        Reset;
  logic        MRxDV;
  logic        MRxDEqD;
  logic        StateIdle;
  logic        StatePreamble;
  logic        StateSFD;
  logic        StateDrop;
  logic [1:0]  StateData;
  logic        HugEn;
  logic        r_IFG;
  logic [15:0] MaxFL;
  logic        DlyCrcEn;
  logic [15:0] ByteCnt;
  logic        ByteCntEq0;
  logic        ByteCntGreat2;
  logic        ByteCntMaxFrame;
  logic        IFGCounterEq24;
  logic        FrameEnd;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] cnt;
    logic        eq0;
    logic        gt2;
    logic        maxf;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_cnt;
  int          m_dly;

  eth_rxframe_ctrl #(.Tp(1)) dut (
    .MRxClk          (MRxClk),
    .Reset           (Reset),
    .MRxDV           (MRxDV),
    .MRxDEqD         (MRxDEqD),
    .StateIdle       (StateIdle),
    .StatePreamble   (StatePreamble),
    .StateSFD        (StateSFD),
    .StateDrop       (StateDrop),
    .StateData       (StateData),
    .HugEn           (HugEn),
    .r_IFG           (r_IFG),
    .MaxFL           (MaxFL),
    .DlyCrcEn        (DlyCrcEn),
    .ByteCnt         (ByteCnt),
    .ByteCntEq0      (ByteCntEq0),
    .ByteCntGreat2   (ByteCntGreat2),
    .ByteCntMaxFrame (ByteCntMaxFrame),
    .IFGCounterEq24  (IFGCounterEq24),
    .FrameEnd        (FrameEnd)
  );

  always #5 MRxClk = ~MRxClk;

  task automatic tick();
    @(posedge MRxClk);
    #1;
  endtask

  function automatic void model_byte();
    logic skip;
    skip = 1'b0;
`ifdef ETH_RX_DLYCRC_EN
    if (DlyCrcEn && m_dly < 4) begin
      m_dly++;
      skip = 1'b1;
    end
`endif
    if (!skip && m_cnt != 16'hFFFF) m_cnt++;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.cnt  = m_cnt;
    e.eq0  = (m_cnt == 16'd0);
    e.gt2  = (m_cnt > 16'd2);
    e.maxf = (m_cnt == MaxFL) && !HugEn;
    return e;
  endfunction

  task automatic go_idle();
    StateIdle = 1'b1; StatePreamble = 1'b0; StateSFD = 1'b0; StateDrop = 1'b0;
    StateData = 2'b00; MRxDV = 1'b0; MRxDEqD = 1'b0;
    tick();
    m_cnt = 16'd0;
    m_dly = 0;
  endtask

  task automatic start_frame();
    StateIdle = 1'b0; StatePreamble = 1'b0; StateSFD = 1'b1; StateDrop = 1'b0;
    StateData = 2'b00; MRxDV = 1'b1; MRxDEqD = 1'b1;
    tick();
    StateSFD  = 1'b0;
    MRxDEqD   = 1'b0;
    StateData = 2'b10;
    m_cnt = 16'd0;
    m_dly = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; MRxDV = 1'b0; MRxDEqD = 1'b0; StateIdle = 1'b1; StatePreamble = 1'b0;
    StateSFD = 1'b0; StateDrop = 1'b0; StateData = 2'b00; HugEn = 1'b0; r_IFG = 1'b0;
    MaxFL = 16'd1518; DlyCrcEn = 1'b0;
    m_cnt = 16'd0; m_dly = 0;
    tick(); tick();
    checks++; if (ByteCnt !== 16'd0) begin errors++;
      $display("FAIL reset_bytecnt got %0h expected 0", ByteCnt); end
    checks++; if (ByteCntEq0 !== 1'b1) begin errors++;
      $display("FAIL reset_eq0 got %b expected 1", ByteCntEq0); end
    checks++; if (ByteCntGreat2 !== 1'b0) begin errors++;
      $display("FAIL reset_gt2 got %b expected 0", ByteCntGreat2); end
    checks++; if (ByteCntMaxFrame !== 1'b0) begin errors++;
      $display("FAIL reset_maxframe got %b expected 0", ByteCntMaxFrame); end
    checks++; if (FrameEnd !== 1'b0) begin errors++;
      $display("FAIL reset_frameend got %b expected 0", FrameEnd); end
    checks++; if (IFGCounterEq24 !== 1'b0) begin errors++;
      $display("FAIL reset_ifg got %b expected 0", IFGCounterEq24); end
    r_IFG = 1'b1;
    #1;
    checks++; if (IFGCounterEq24 !== 1'b1) begin errors++;
      $display("FAIL reset_ifg_override got %b expected 1", IFGCounterEq24); end
    r_IFG = 1'b0;
    #1;
  endtask

  task automatic test_ifg_idle();
    StateIdle = 1'b1;
    Reset = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checks++;
      if (IFGCounterEq24 !== (i >= 24)) begin errors++;
        $display("FAIL ifg_idle cycle %0d got %b expected %b", i, IFGCounterEq24, i >= 24);
      end
    end
  endtask

  task automatic test_frame_64();
    exp_t e;
    DlyCrcEn = 1'b0;
    start_frame();
    checks++; if (IFGCounterEq24 !== 1'b0) begin errors++;
      $display("FAIL frame_start_ifg_clear got %b expected 0", IFGCounterEq24); end
    checks++; if (ByteCnt !== 16'd0) begin errors++;
      $display("FAIL frame_start_bytecnt got %0d expected 0", ByteCnt); end
    for (int i = 1; i <= 64; i++) begin
      model_byte();
      sb.push_back(model_expect());
      tick();
      e = sb.pop_front();
      checks++;
      if (ByteCnt !== e.cnt || ByteCntEq0 !== e.eq0 || ByteCntGreat2 !== e.gt2 ||
          FrameEnd !== 1'b0) begin
        errors++;
        $display("FAIL frame64 byte %0d got cnt=%0d eq0=%b gt2=%b fe=%b expected %0d %b %b 0",
                 i, ByteCnt, ByteCntEq0, ByteCntGreat2, FrameEnd, e.cnt, e.eq0, e.gt2);
      end
    end
    MRxDV = 1'b0;
    tick();
    checks++; if (FrameEnd !== 1'b1 || ByteCnt !== 16'd64) begin errors++;
      $display("FAIL frame_end_pulse got fe=%b cnt=%0d expected 1 64", FrameEnd, ByteCnt); end
    go_idle();
    checks++; if (FrameEnd !== 1'b0 || ByteCnt !== 16'd0) begin errors++;
      $display("FAIL frame_end_drop got fe=%b cnt=%0d expected 0 0", FrameEnd, ByteCnt); end
  endtask

  task automatic test_max_frame();
    exp_t e;
    int   hits;
    MaxFL = 16'd1518;
    for (int pass = 0; pass < 2; pass++) begin
      HugEn = (pass == 1);
      hits  = 0;
      start_frame();
      for (int i = 1; i <= 1520; i++) begin
        model_byte();
        sb.push_back(model_expect());
        tick();
        e = sb.pop_front();
        if (ByteCntMaxFrame === 1'b1) hits++;
        checks++;
        if (ByteCnt !== e.cnt || ByteCntMaxFrame !== e.maxf) begin errors++;
          $display("FAIL maxframe hug=%b byte %0d got cnt=%0d mf=%b expected %0d %b",
                   HugEn, i, ByteCnt, ByteCntMaxFrame, e.cnt, e.maxf);
        end
      end
      checks++;
      if (hits !== (pass == 0 ? 1 : 0)) begin errors++;
        $display("FAIL maxframe_hits hug=%b got %0d expected %0d", HugEn, hits,
                 pass == 0 ? 1 : 0);
      end
      go_idle();
    end
    HugEn = 1'b0;
  endtask

  task automatic test_dlycrc();
    exp_t        e;
    logic [15:0] want;
`ifdef ETH_RX_DLYCRC_EN
    want = 16'd6;
`else
    want = 16'd10;
`endif
    DlyCrcEn = 1'b1;
    start_frame();
    for (int i = 1; i <= 10; i++) begin
      model_byte();
      sb.push_back(model_expect());
      tick();
      e = sb.pop_front();
      checks++;
      if (ByteCnt !== e.cnt) begin errors++;
        $display("FAIL dlycrc byte %0d got %0d expected %0d", i, ByteCnt, e.cnt); end
    end
    checks++; if (ByteCnt !== want) begin errors++;
      $display("FAIL dlycrc_total got %0d expected %0d", ByteCnt, want); end
    go_idle();
    DlyCrcEn = 1'b0;
  endtask

  task automatic test_clear_priority();
    start_frame();
    for (int i = 0; i < 5; i++) tick();
    StateIdle = 1'b1;
    tick();
    checks++; if (ByteCnt !== 16'd0) begin errors++;
      $display("FAIL clear_priority got %0d expected 0", ByteCnt); end
    go_idle();
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    start_frame();
    for (int i = 1; i <= 100; i++) begin
      model_byte();
      sb.push_back(model_expect());
      tick();
      e = sb.pop_front();
      checks++;
      if (ByteCnt !== e.cnt) begin errors++;
        $display("FAIL midreset_fill byte %0d got %0d expected %0d", i, ByteCnt, e.cnt); end
    end
    MRxDV = 1'b0;
    tick();
    checks++; if (FrameEnd !== 1'b1) begin errors++;
      $display("FAIL midreset_pre_fe got %b expected 1", FrameEnd); end
    Reset = 1'b1;
    #1;
    checks++; if (ByteCnt !== 16'd0 || FrameEnd !== 1'b0 || ByteCntEq0 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async got cnt=%0d fe=%b eq0=%b expected 0 0 1",
               ByteCnt, FrameEnd, ByteCntEq0);
    end
    go_idle();
    Reset = 1'b0;
    tick();
    start_frame();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (ByteCnt !== 16'd3) begin errors++;
      $display("FAIL midreset_resume got %0d expected 3", ByteCnt); end
    go_idle();
  endtask

  task automatic test_saturate();
    exp_t e;
    HugEn = 1'b1;
    start_frame();
    for (int i = 1; i <= 65540; i++) begin
      model_byte();
      sb.push_back(model_expect());
      tick();
      e = sb.pop_front();
      if (i > 65530) begin
        checks++;
        if (ByteCnt !== e.cnt || ByteCntMaxFrame !== 1'b0) begin errors++;
          $display("FAIL saturate byte %0d got cnt=%0h mf=%b expected %0h 0",
                   i, ByteCnt, ByteCntMaxFrame, e.cnt);
        end
      end
    end
    checks++; if (ByteCnt !== 16'hFFFF) begin errors++;
      $display("FAIL saturate_final got %0h expected ffff", ByteCnt); end
    go_idle();
    HugEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifg_idle();
    test_frame_64();
    test_max_frame();
    test_dlycrc();
    test_clear_priority();
    test_reset_mid_frame();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
